// File: rtl/cpu_host_pkg.sv
// Shared constants for the host bridge: host opcodes, core cmd encodings and FSM states.
package cpu_host_pkg;

    localparam logic [7:0] OP_IWR  = 8'h01;
    localparam logic [7:0] OP_DWR  = 8'h03;
    localparam logic [7:0] OP_RRD  = 8'h10;
    localparam logic [7:0] OP_DRD  = 8'h12;
    localparam logic [7:0] OP_HOLD = 8'h20;
    localparam logic [7:0] OP_RUN  = 8'h21;

    localparam logic [1:0] CMD_RREG = 2'b00;
    localparam logic [1:0] CMD_IWR  = 2'b01;
    localparam logic [1:0] CMD_DRD  = 2'b10;
    localparam logic [1:0] CMD_DWR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_EXEC,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [1:0] op_to_cmd(input logic [7:0] op);
        case (op)
            OP_IWR:  return CMD_IWR;
            OP_DWR:  return CMD_DWR;
            OP_DRD:  return CMD_DRD;
            default: return CMD_RREG;
        endcase
    endfunction

    function automatic logic op_is_write(input logic [7:0] op);
        return (op == OP_IWR) || (op == OP_DWR);
    endfunction

endpackage

// File: rtl/host_resp_serializer.sv
// Response byte serializer: loads a 1- or 4-byte response and shifts it out LSB first
// over a valid/ready byte stream; done pulses on the handshake of the final byte.
module host_resp_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        load_wide,
    input  logic [31:0] load_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] shift;
    logic [1:0]  left;

    assign tx_data = shift[7:0];
    assign done    = tx_valid && tx_ready && (left == 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift    <= 32'h0;
            left     <= 2'd0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shift    <= load_data;
            left     <= load_wide ? 2'd3 : 2'd0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (left == 2'd0) begin
                tx_valid <= 1'b0;
            end else begin
                shift <= {8'h00, shift[31:8]};
                left  <= left - 2'd1;
            end
        end
    end

endmodule

// File: rtl/cpu_host_bridge.sv
// Host command sequencer driving the core's cmd/addr/data port from a framed byte stream.
// Optional inter-byte timeout is enabled by defining HOST_BRIDGE_TIMEOUT_EN.
module cpu_host_bridge #(
    parameter int          READ_LAT       = 2,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  cpu_cmd,
    output logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    input  logic [31:0] cpu_data_out,
    output logic        cpu_hold,
    output logic        busy
);
    import cpu_host_pkg::*;

    // state | meaning
    // IDLE  | waiting for opcode byte
    // ADDR  | collecting 4 address bytes, LSB first
    // DATA  | collecting 4 write-data bytes, LSB first
    // EXEC  | single cycle with the access cmd on the core port
    // WAIT  | read cmd held until core data is valid
    // RESP  | serializer draining ack/err/read data

    state_t      state, next_state;
    logic        ready_en;
    logic [7:0]  opcode;
    logic [1:0]  cnt;
    logic [7:0]  wcnt;
    logic        accept, abort, is_frame_op;
    logic        resp_load, resp_wide, resp_done;
    logic [31:0] resp_data;

    assign rx_ready    = ready_en && (state == ST_IDLE || state == ST_ADDR || state == ST_DATA);
    assign accept      = rx_valid && rx_ready;
    assign busy        = (state != ST_IDLE);
    assign is_frame_op = (rx_data == OP_IWR) || (rx_data == OP_DWR) ||
                         (rx_data == OP_RRD) || (rx_data == OP_DRD);

`ifdef HOST_BRIDGE_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            gap <= '0;
        else if ((state == ST_ADDR || state == ST_DATA) && !accept)
            gap <= gap + 1'b1;
        else
            gap <= '0;
    end

    assign abort = (state == ST_ADDR || state == ST_DATA) && (gap == GAP_W'(TIMEOUT_CYCLES));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        cpu_cmd    = CMD_RREG;
        resp_load  = 1'b0;
        resp_wide  = 1'b0;
        resp_data  = {24'h0, ACK_BYTE};
        case (state)
            ST_IDLE: if (accept) begin
                if (rx_data == OP_HOLD || rx_data == OP_RUN) begin
                    resp_load  = 1'b1;
                    next_state = ST_RESP;
                end else if (is_frame_op) begin
                    next_state = ST_ADDR;
                end else begin
                    resp_load  = 1'b1;
                    resp_data  = {24'h0, ERR_BYTE};
                    next_state = ST_RESP;
                end
            end
            ST_ADDR, ST_DATA: if (accept) begin
                if (cnt == 2'd3)
                    next_state = (state == ST_ADDR && op_is_write(opcode)) ? ST_DATA : ST_EXEC;
            end else if (abort) begin
                resp_load  = 1'b1;
                resp_data  = {24'h0, ERR_BYTE};
                next_state = ST_RESP;
            end
            ST_EXEC: begin
                cpu_cmd = op_to_cmd(opcode);
                if (op_is_write(opcode)) begin
                    resp_load  = 1'b1;
                    next_state = ST_RESP;
                end else begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cpu_cmd = op_to_cmd(opcode);
                if (wcnt == 8'(READ_LAT - 1)) begin
                    resp_load  = 1'b1;
                    resp_wide  = 1'b1;
                    resp_data  = cpu_data_out;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: if (resp_done) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Address/data shift straight into the core-facing registers; they keep their value between frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
            opcode   <= 8'h00;
            cnt      <= 2'd0;
            wcnt     <= 8'd0;
            cpu_addr <= 32'h0;
            cpu_data <= 32'h0;
            cpu_hold <= 1'b1;
        end else begin
            ready_en <= 1'b1;
            if (state == ST_IDLE && accept) begin
                opcode <= rx_data;
                cnt    <= 2'd0;
                if (rx_data == OP_HOLD) cpu_hold <= 1'b1;
                if (rx_data == OP_RUN)  cpu_hold <= 1'b0;
            end
            if (state == ST_ADDR && accept) begin
                cpu_addr[{cnt, 3'b000} +: 8] <= rx_data;
                cnt <= cnt + 2'd1;
            end
            if (state == ST_DATA && accept) begin
                cpu_data[{cnt, 3'b000} +: 8] <= rx_data;
                cnt <= cnt + 2'd1;
            end
            if (state == ST_EXEC)      wcnt <= 8'd0;
            else if (state == ST_WAIT) wcnt <= wcnt + 8'd1;
        end
    end

    host_resp_serializer u_resp (
        .clk       (clk),
        .reset     (reset),
        .load      (resp_load),
        .load_wide (resp_wide),
        .load_data (resp_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (resp_done)
    );

endmodule

// File: tb/tb_cpu_host_bridge.sv
// Directed bench for cpu_host_bridge with a small core model (2-cycle read pipeline).
module tb_cpu_host_bridge;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  cpu_cmd;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic [31:0] cpu_data_out;
    logic        cpu_hold;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    cpu_host_bridge #(.READ_LAT(2), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cpu_cmd(cpu_cmd),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_data_out(cpu_data_out),
        .cpu_hold(cpu_hold), .busy(busy)
    );

    always #5 clk = ~clk;

    // core model: D-cache writes on cmd 11, read data valid two cycles after cmd/addr
    logic [31:0] dmem [0:255];
    logic [31:0] regs [0:31];
    logic [31:0] p1 = 32'h0, p2 = 32'h0;
    assign cpu_data_out = p2;

    always @(posedge clk) begin
        if (cpu_cmd == 2'b11) dmem[cpu_addr[9:2]] <= cpu_data;
        p1 <= (cpu_cmd == 2'b10) ? dmem[cpu_addr[9:2]] : regs[cpu_addr[4:0]];
        p2 <= p1;
    end

    int iwr_cyc = 0, dwr_cyc = 0, nz_cyc = 0, wr_run = 0, wr_run_max = 0;
    logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;

    always @(posedge clk) begin
        if (cpu_cmd == 2'b01) iwr_cyc++;
        if (cpu_cmd == 2'b11) dwr_cyc++;
        if (cpu_cmd != 2'b00) nz_cyc++;
        if (cpu_cmd[0]) begin
            wr_run++;
            if (wr_run > wr_run_max) wr_run_max = wr_run;
            last_wr_addr = cpu_addr;
            last_wr_data = cpu_data;
        end else begin
            wr_run = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin @(negedge clk); n++; end
        if (!rx_ready) begin
            compared++; mismatched++;
            $display("FAIL send_wait: rx_ready=0 after %0d cycles, required 1", n);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n;
        n = 0;
        while (!tx_valid && n < 200) begin @(negedge clk); n++; end
        compared++;
        if (!tx_valid) begin
            mismatched++;
            $display("FAIL recv_wait: tx_valid=0 after %0d cycles, required 1", n);
        end
        b = tx_data;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        compared++; if (cpu_hold !== 1'b1) begin mismatched++; $display("FAIL rst_hold: got %b want 1", cpu_hold); end
        compared++; if (cpu_cmd !== 2'b00) begin mismatched++; $display("FAIL rst_cmd: got %b want 00", cpu_cmd); end
        compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("FAIL rst_txv: got %b want 0", tx_valid); end
        compared++; if (tx_data !== 8'h00) begin mismatched++; $display("FAIL rst_txd: got %h want 00", tx_data); end
        compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("FAIL rst_rxr: got %b want 0", rx_ready); end
        compared++; if ({cpu_addr, cpu_data} !== 64'h0) begin mismatched++; $display("FAIL rst_addr_data: got %h want 0", {cpu_addr, cpu_data}); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b1;
        #1;
        compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("FAIL rel_rxr0: got %b want 0", rx_ready); end
        @(negedge clk);
        compared++; if (rx_ready !== 1'b1) begin mismatched++; $display("FAIL rel_rxr1: got %b want 1", rx_ready); end
    endtask

    task automatic test_hold;
        logic [7:0] b;
        send_byte(8'h21);
        compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("FAIL run_hold: got %b want 0", cpu_hold); end
        recv_byte(b);
        compared++; if (b !== 8'hA5) begin mismatched++; $display("FAIL run_ack: got %h want a5", b); end
        send_byte(8'h20);
        compared++; if (cpu_hold !== 1'b1) begin mismatched++; $display("FAIL hold_hold: got %b want 1", cpu_hold); end
        recv_byte(b);
        compared++; if (b !== 8'hA5) begin mismatched++; $display("FAIL hold_ack: got %h want a5", b); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL hold_busy: got %b want 0", busy); end
    endtask

    task automatic test_iwrite;
        logic [7:0] b;
        logic [7:0] fr [0:8];
        int i0;
        fr = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        i0 = iwr_cyc;
        for (int i = 0; i < 9; i++) send_byte(fr[i]);
        recv_byte(b);
        compared++; if (b !== 8'hA5) begin mismatched++; $display("FAIL iwr_ack: got %h want a5", b); end
        compared++; if (iwr_cyc - i0 !== 1) begin mismatched++; $display("FAIL iwr_cycles: got %0d want 1", iwr_cyc - i0); end
        compared++; if (last_wr_addr !== 32'h10) begin mismatched++; $display("FAIL iwr_addr: got %h want 00000010", last_wr_addr); end
        compared++; if (last_wr_data !== 32'h13) begin mismatched++; $display("FAIL iwr_data: got %h want 00000013", last_wr_data); end
        compared++; if (cpu_cmd !== 2'b00) begin mismatched++; $display("FAIL iwr_cmd_idle: got %b want 00", cpu_cmd); end
    endtask

    task automatic test_dwrite_read;
        logic [7:0] b;
        logic [7:0] fr [0:8];
        logic [7:0] exp [0:3];
        int d0;
        fr  = '{8'h03, 8'h40, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        d0 = dwr_cyc;
        for (int i = 0; i < 9; i++) send_byte(fr[i]);
        recv_byte(b);
        compared++; if (b !== 8'hA5) begin mismatched++; $display("FAIL dwr_ack: got %h want a5", b); end
        compared++; if (dwr_cyc - d0 !== 1) begin mismatched++; $display("FAIL dwr_cycles: got %0d want 1", dwr_cyc - d0); end
        compared++; if (last_wr_data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL dwr_data: got %h want deadbeef", last_wr_data); end
        send_byte(8'h12);
        for (int i = 0; i < 4; i++) send_byte(fr[i + 1]);
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            compared++; if (b !== exp[i]) begin mismatched++; $display("FAIL drd_byte%0d: got %h want %h", i, b, exp[i]); end
        end
        compared++; if (cpu_addr !== 32'h40) begin mismatched++; $display("FAIL drd_addr_kept: got %h want 00000040", cpu_addr); end
        compared++; if (cpu_data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL drd_data_kept: got %h want deadbeef", cpu_data); end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [0:3];
        int n, w0;
        exp = '{8'h78, 8'h56, 8'h34, 8'h12};
        w0 = iwr_cyc + dwr_cyc;
        send_byte(8'h10);
        send_byte(8'h05);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 5; s++) begin
                compared++;
                if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                    mismatched++;
                    $display("FAIL bp_stall%0d_%0d: got v=%b d=%h want v=1 d=%h", i, s, tx_valid, tx_data, exp[i]);
                end
                @(negedge clk);
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            if (i < 3) begin
                compared++;
                if (tx_valid !== 1'b1 || tx_data !== exp[i + 1]) begin
                    mismatched++;
                    $display("FAIL bp_next%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i + 1]);
                end
            end
        end
        compared++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL bp_end: got v=%b busy=%b want 0 0", tx_valid, busy); end
        compared++; if (iwr_cyc + dwr_cyc - w0 !== 0) begin mismatched++; $display("FAIL bp_no_write: got %0d want 0", iwr_cyc + dwr_cyc - w0); end
    endtask

    task automatic test_bad_opcode;
        logic [7:0] b;
        int z0;
        z0 = nz_cyc;
        send_byte(8'h7F);
        recv_byte(b);
        compared++; if (b !== 8'hEE) begin mismatched++; $display("FAIL bad_err: got %h want ee", b); end
        compared++; if (nz_cyc - z0 !== 0) begin mismatched++; $display("FAIL bad_cmd: got %0d active cycles want 0", nz_cyc - z0); end
        send_byte(8'h21);
        recv_byte(b);
        compared++; if (b !== 8'hA5 || cpu_hold !== 1'b0) begin mismatched++; $display("FAIL bad_next: got %h hold=%b want a5 hold=0", b, cpu_hold); end
    endtask

    task automatic test_back_to_back;
        tx_ready = 1'b1;
        send_byte(8'h20);
        rx_data  = 8'h21;
        rx_valid = 1'b1;
        compared++; if (rx_ready !== 1'b0 || tx_valid !== 1'b1 || cpu_hold !== 1'b1) begin mismatched++; $display("FAIL b2b_resp: got rxr=%b txv=%b hold=%b want 0 1 1", rx_ready, tx_valid, cpu_hold); end
        @(negedge clk);
        compared++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: got rxr=%b txv=%b want 1 0", rx_ready, tx_valid); end
        @(negedge clk);
        rx_valid = 1'b0;
        compared++; if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5 || cpu_hold !== 1'b0) begin mismatched++; $display("FAIL b2b_second: got busy=%b txv=%b txd=%h hold=%b want 1 1 a5 0", busy, tx_valid, tx_data, cpu_hold); end
        @(negedge clk);
        tx_ready = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_done: got busy=%b want 0", busy); end
    endtask

    task automatic test_partial_frame;
        logic [7:0] b;
        int z0, n;
        z0 = nz_cyc;
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h00);
`ifdef HOST_BRIDGE_TIMEOUT_EN
        n = 0;
        while (!tx_valid && n < TMO + 20) begin @(negedge clk); n++; end
        compared++; if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin mismatched++; $display("FAIL tmo_err: got v=%b d=%h want v=1 d=ee", tx_valid, tx_data); end
        compared++; if (n < TMO - 2) begin mismatched++; $display("FAIL tmo_early: got %0d cycles want >= %0d", n, TMO - 2); end
        recv_byte(b);
        compared++; if (nz_cyc - z0 !== 0 || busy !== 1'b0) begin mismatched++; $display("FAIL tmo_cmd: got %0d cmd cycles busy=%b want 0 0", nz_cyc - z0, busy); end
`else
        n = 0;
        repeat (100) begin @(negedge clk); n++; end
        compared++; if (busy !== 1'b1 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin mismatched++; $display("FAIL part_wait: after %0d got busy=%b txv=%b rxr=%b want 1 0 1", n, busy, tx_valid, rx_ready); end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        recv_byte(b);
        compared++; if (b !== 8'hA5) begin mismatched++; $display("FAIL part_ack: got %h want a5", b); end
        compared++; if (last_wr_addr !== 32'h20 || last_wr_data !== 32'h04030201) begin mismatched++; $display("FAIL part_wr: got %h/%h want 00000020/04030201", last_wr_addr, last_wr_data); end
        compared++; if (nz_cyc - z0 !== 1) begin mismatched++; $display("FAIL part_cmd: got %0d cmd cycles want 1", nz_cyc - z0); end
`endif
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        reset = 1'b0;
        #1;
        compared++; if (busy !== 1'b0 || cpu_hold !== 1'b1 || cpu_cmd !== 2'b00) begin mismatched++; $display("FAIL mid_rst_ctl: got busy=%b hold=%b cmd=%b want 0 1 00", busy, cpu_hold, cpu_cmd); end
        compared++; if (cpu_addr !== 32'h0 || cpu_data !== 32'h0) begin mismatched++; $display("FAIL mid_rst_ad: got %h/%h want 0/0", cpu_addr, cpu_data); end
        compared++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b0) begin mismatched++; $display("FAIL mid_rst_io: got txv=%b txd=%h rxr=%b want 0 00 0", tx_valid, tx_data, rx_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++; if (rx_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL mid_rst_rel: got rxr=%b busy=%b want 1 0", rx_ready, busy); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[5]  = 32'h12345678;
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_hold();
        test_iwrite();
        test_dwrite_read();
        test_backpressure();
        test_bad_opcode();
        test_back_to_back();
        test_partial_frame();
        compared++; if (wr_run_max !== 1) begin mismatched++; $display("FAIL wr_pulse_len: got %0d want 1", wr_run_max); end
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
